// File: rtl/fetch_stage_pkg.sv
// Shared MIPS pipeline constants used by IF, ID and the hazard unit.
package fetch_stage_pkg;

    localparam int          ADDR_W           = 32;
    localparam int          JIDX_W           = 26;
    localparam logic [31:0] NOP_INSTR_C      = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // j/jal target: upper nibble of the delay-slot PC, word index, word aligned.
    function automatic logic [ADDR_W-1:0] jump_target(
        input logic [ADDR_W-1:0] pc4,
        input logic [JIDX_W-1:0] index
    );
        return {pc4[ADDR_W-1:ADDR_W-4], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid, with write enable
// and a flush that loads a bubble.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              write,
    input  logic [ADDR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0] pc4_in,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] pc4,
    output logic              valid
);

    // Flush beats a held register so a redirect always kills the wrong-path word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (write) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register
// and a saturating stall counter for performance debugging.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [ADDR_W-1:0] imem_rdata,
    input  logic              pc_write,
    input  logic              ifid_write,
    input  logic              ifid_flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic              ifid_valid,
    output logic [15:0]       stall_cnt
);

    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc4;
    logic              redirect;
    logic [15:0]       stall_q;
    logic              unused_target_bits;

    assign pc4                = pc_q + 32'd4;
    assign redirect           = pc_write & (branch_taken | jump);
    assign imem_addr          = pc_q;
    assign pc                 = pc_q;
    assign stall_cnt          = stall_q;
    assign unused_target_bits = ^branch_target[1:0];

    // Next PC: a stall masks redirects; branch outranks jump; else sequential.
    always_comb begin
        pc_next = pc4;
        if (!pc_write) begin
            pc_next = pc_q;
        end else if (branch_taken) begin
            pc_next = {branch_target[ADDR_W-1:2], 2'b00};
        end else if (jump) begin
            pc_next = jump_target(ifid_pc4, jump_index);
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC_ALIGNED;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Count stalled cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!pc_write && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (ifid_flush | redirect),
        .write    (ifid_write),
        .instr_in (imem_rdata),
        .pc4_in   (pc4),
        .instr    (ifid_instr),
        .pc4      (ifid_pc4),
        .valid    (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked
// against a cycle-level reference model built from the stage's rules.
module tb_fetch_stage;

    localparam int W = 32 + 32 + 32 + 1 + 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        pc_write = 1'b1;
    logic        ifid_write = 1'b1;
    logic        ifid_flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [15:0] stall_cnt;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .stall_cnt     (stall_cnt)
    );

    // Word n of memory is 32'h2000_0000 + n.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc4   = '0;
    logic        m_valid = 1'b0;
    int          m_stalls = 0;   // unbounded count; saturation applied on read

    logic [W-1:0] exp_q[$];

    task automatic model_step(input logic r, input logic pw, input logic iw, input logic fl,
                              input logic bt, input logic [31:0] tgt,
                              input logic j, input logic [25:0] ji);
        logic [31:0] seq;
        logic [31:0] npc;
        logic        taken;
        if (!r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_stalls = 0;
            return;
        end
        seq   = m_pc + 32'd4;
        taken = pw && (bt || j);
        if (!pw)     npc = m_pc;
        else if (bt) npc = tgt & 32'hFFFF_FFFC;
        else if (j)  npc = (m_pc4 & 32'hF000_0000) | ({6'b0, ji} << 2);
        else         npc = seq;
        if (fl || taken) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (iw) begin
            m_instr = mem_word(m_pc); m_pc4 = seq; m_valid = 1'b1;
        end
        if (!pw) m_stalls++;
        m_pc = npc;
    endtask

    function automatic logic [15:0] sat_stalls();
        return (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic pw, input logic iw, input logic fl,
                         input logic bt, input logic [31:0] tgt,
                         input logic j, input logic [25:0] ji);
        logic [W-1:0] e;
        @(negedge clk);
        rst_n = r; pc_write = pw; ifid_write = iw; ifid_flush = fl;
        branch_taken = bt; branch_target = tgt; jump = j; jump_index = ji;
        model_step(r, pw, iw, fl, bt, tgt, j, ji);
        exp_q.push_back({m_pc, m_instr, m_pc4, m_valid, sat_stalls()});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pc",         pc,                 e[W-1 -: 32]);
        check("imem_addr",  imem_addr,          e[W-1 -: 32]);
        check("ifid_instr", ifid_instr,         e[W-33 -: 32]);
        check("ifid_pc4",   ifid_pc4,           e[W-65 -: 32]);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, e[16]});
        check("stall_cnt",  {16'b0, stall_cnt},  {16'b0, e[15:0]});
    endtask

    task automatic step_normal();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    task automatic step_stall(input logic bt, input logic [31:0] tgt);
        drive(1'b1, 1'b0, 1'b0, 1'b0, bt, tgt, 1'b0, 26'h0);
    endtask

    task automatic step_branch(input logic [31:0] tgt);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, tgt, 1'b0, 26'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_valid", {31'b0, ifid_valid}, 32'h0);
        check("rst_stall", {16'b0, stall_cnt}, 32'h0);

        // Reset release: sequential fetch
        step_normal();
        check("rel_pc1", pc, 32'h4);
        check("rel_instr1", ifid_instr, 32'h2000_0000);
        check("rel_pc4_1", ifid_pc4, 32'h4);
        check("rel_valid1", {31'b0, ifid_valid}, 32'h1);
        step_normal();
        check("rel_pc2", pc, 32'h8);
        check("rel_instr2", ifid_instr, 32'h2000_0001);

        // Taken branch at pc=8 to 0x43 (low bits ignored)
        step_branch(32'h0000_0043);
        check("br_pc", pc, 32'h40);
        check("br_bubble_instr", ifid_instr, 32'h0);
        check("br_bubble_valid", {31'b0, ifid_valid}, 32'h0);
        step_normal();
        check("br_pc4", ifid_pc4, 32'h44);
        check("br_instr", ifid_instr, 32'h2000_0010);

        // Jump with ifid_pc4 = A000_0010
        step_branch(32'hA000_000C);
        step_normal();
        check("jmp_setup_pc4", ifid_pc4, 32'hA000_0010);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h0000100);
        check("jmp_pc", pc, 32'hA000_0400);
        // Branch and jump together: branch wins
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0123, 1'b1, 26'h0000100);
        check("brj_pc", pc, 32'h0000_0120);

        // Three-cycle stall with a masked branch in the middle
        step_stall(1'b0, 32'h0);
        step_stall(1'b1, 32'h0000_0800);
        step_stall(1'b0, 32'h0);
        check("stl_pc", pc, 32'h0000_0120);
        check("stl_cnt", {16'b0, stall_cnt}, 32'd3);

        // Saturation of the stall counter
        for (int i = 0; i < 65532; i++) step_stall(1'b0, 32'h0);
        check("sat_cnt", {16'b0, stall_cnt}, 32'h0000_FFFF);
        step_stall(1'b0, 32'h0);
        step_stall(1'b0, 32'h0);
        check("sat_hold", {16'b0, stall_cnt}, 32'h0000_FFFF);

        // Flush overrides a held IF/ID
        step_normal();
        check("pre_flush_valid", {31'b0, ifid_valid}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        check("flush_valid", {31'b0, ifid_valid}, 32'h0);
        check("flush_instr", ifid_instr, 32'h0);

        // PC wrap-around
        step_branch(32'hFFFF_FFFC);
        step_normal();
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc4", ifid_pc4, 32'h0);
        check("wrap_instr", ifid_instr, 32'h2000_0000 + 32'h3FFF_FFFF);

        // Reset while stalling with a pending branch
        step_normal();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b0, 26'h0);
        check("mrst_pc", pc, 32'h0);
        check("mrst_valid", {31'b0, ifid_valid}, 32'h0);
        check("mrst_stall", {16'b0, stall_cnt}, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 31) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom(),
                  $urandom_range(0, 5) == 0,
                  26'($urandom()));
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. `ifid_instr[15:0]` is the immediate field consumed by the ID-stage sign extender and `ifid_pc4` feeds branch-target and jump-target formation in ID. The block supports hazard-unit stalls, branch and jump redirects resolved in ID, and an external flush. It also keeps a saturating stall counter for performance debugging.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000, bubble inserted on flush (`sll $0,$0,0`).

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `imem_addr`  out  32  instruction-memory address, equal to `pc` (combinational).
- `imem_rdata`  in  32  instruction word at `imem_addr`, valid in the same cycle (asynchronous-read memory).
- `pc_write`  in  1  0 holds the PC (hazard-unit stall).
- `ifid_write`  in  1  0 holds the IF/ID register.
- `ifid_flush`  in  1  1 loads a bubble into IF/ID.
- `branch_taken`  in  1  ID-resolved taken branch.
- `branch_target`  in  32  branch target from ID; bits [1:0] ignored.
- `jump`  in  1  ID-decoded `j`/`jal`.
- `jump_index`  in  26  instruction bits [25:0] of the jump in ID.
- `pc`  out  32  current fetch PC.
- `ifid_instr`  out  32  registered instruction.
- `ifid_pc4`  out  32  registered PC+4 of `ifid_instr`.
- `ifid_valid`  out  1  0 when IF/ID holds a bubble.
- `stall_cnt`  out  16  count of cycles with `pc_write`=0.

## Operation
- `pc4 = pc + 4`, modulo 2^32: 32'hFFFF_FFFC wraps to 0. `pc[1:0]` is always 2'b00.
- Jump target = {`ifid_pc4[31:28]`, `jump_index`, 2'b00}. Branch target = {`branch_target[31:2]`, 2'b00}.
- PC next-state priority:
  - `!rst_n` → `RESET_PC`.
  - `pc_write`=0 → hold. A stall masks any redirect; the hazard unit re-asserts the redirect when the stall ends.
  - `branch_taken` → branch target. Branch wins if `jump` is asserted in the same cycle.
  - `jump` → jump target.
  - Otherwise → `pc4`.
- `redirect = pc_write & (branch_taken | jump)`.
- IF/ID next-state priority:
  - `!rst_n` → reset values.
  - `ifid_flush | redirect` → `NOP_INSTR`, `ifid_pc4`=0, `ifid_valid`=0. Flush overrides `ifid_write`=0.
  - `ifid_write`=0 → hold all three fields.
  - Otherwise → `imem_rdata`, `pc4`, 1.
- `stall_cnt` increments on each cycle with `rst_n`=1 and `pc_write`=0, and saturates at 16'hFFFF.

## Timing
- Reset values: `pc`=`RESET_PC`, `ifid_instr`=`NOP_INSTR`, `ifid_pc4`=0, `ifid_valid`=0, `stall_cnt`=0. Reset asserted mid-stream takes effect at the next edge and discards any pending redirect or stall.
- Fetch latency is 1 cycle: the word at `pc`=A in cycle t appears on `ifid_instr` in t+1, with `ifid_pc4`=A+4.
- Redirect asserted in cycle t: `pc`=target in t+1, IF/ID holds a bubble in t+1, and the target instruction reaches IF/ID in t+2. The branch penalty is 1 cycle.
- Load-use stall (`pc_write`=`ifid_write`=0 for 1 cycle): `pc` and IF/ID are both unchanged for one edge, and `stall_cnt` rises by 1.
- The first valid instruction after reset appears in IF/ID one cycle after `rst_n` rises.

## Structure
- Shared pipeline package holds `NOP_INSTR`, the default `RESET_PC`, the address width (32) and the jump-index width (26). The ID stage and hazard unit use the same constants.
- One natural sub-module, `ifid_reg`: the write-enable/flush register carrying the instruction, pc4 and valid fields. The PC register, next-PC mux and stall counter stay in `fetch_stage`.

## Test plan
- **Reset release:** `RESET_PC`=0, memory word n = 32'h2000_0000+n. After `rst_n` rises, `pc` steps 0, 4, 8, and `ifid_instr`/`ifid_pc4` follow one cycle later (32'h2000_0000/4, …), with `ifid_valid`=1 from the second cycle.
- **Taken branch:** `branch_taken`=1, `branch_target`=32'h0000_0043 at `pc`=8. Next cycle `pc`=32'h40 and IF/ID = NOP with valid=0; the cycle after, `ifid_pc4`=32'h44.
- **Jump:** `ifid_pc4`=32'hA000_0010, `jump_index`=26'h0000100, `jump`=1. Next cycle `pc`=32'hA000_0400. Same test with `branch_taken`=1 simultaneously: branch target wins.
- **Stall:** `pc_write`=`ifid_write`=0 for 3 cycles with `branch_taken`=1 in the middle cycle. `pc` and IF/ID are frozen and no redirect occurs; `stall_cnt`=3. After `stall_cnt` is forced to 16'hFFFF, further stalls leave it at 16'hFFFF.
- **Flush vs hold and wrap-around:** `ifid_flush`=1 with `ifid_write`=0 → IF/ID becomes NOP/valid=0. PC at 32'hFFFF_FFFC steps to 0, and the next `ifid_pc4`=0.
- **Reset mid-stall:** `rst_n`=0 while `pc_write`=0 → all outputs return to their reset values at the next edge.
